reset_seq_ctrl: RTL and testbench

- Parametrised reset sequencer for the image pipe.
- Takes one board-level async reset and produces NUM_DOMAINS synchronised, staggered, active-low domain resets (e.g. datapath, register/CPU).
- Supports two software-initiated resets: a global re-sequence and per-domain reset pulses.
- Sits at top level between the reset pin and every block reset input; exposes done/busy status to the register block.

---
 rtl/reset_seq_pkg.sv | 18 +
 rtl/reset_sync.sv | 24 ++
 rtl/reset_seq_ctrl.sv | 163 ++++++++++++++++
 tb/tb_reset_seq_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared types and sizing helpers
// for the reset sequencer
package reset_seq_pkg;

   typedef enum logic [1:0] {
      ST_SYNC,
      ST_HOLD,
      ST_RELEASE,
      ST_RUN
   } rs_state_e;

   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/reset_sync.sv
// reset_sync: async-assert, sync-deassert
// reset synchroniser chain
module reset_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic s_rst_n,
   output logic rst_sync_n
);

   logic [SYNC_STAGES-1:0] ff;

   // shift ones in after release, clear at once on assert
   always_ff @(posedge clk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         ff <= '0;
      end else begin
         ff <= {ff[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign rst_sync_n = ff[SYNC_STAGES-1];

endmodule

// File: rtl/reset_seq_ctrl.sv
// reset_seq_ctrl: staggered domain reset sequencer
// with sw re-sequence and per-domain reset pulses
module reset_seq_ctrl
   import reset_seq_pkg::*;
#(
   parameter int NUM_DOMAINS  = 2,
   parameter int SYNC_STAGES  = 2,
   parameter int PULSE_CYCLES = 8,
   parameter int GAP_CYCLES   = 4
) (
   input  logic                   clk,
   input  logic                   s_rst_n,
   input  logic                   sw_rst_all,
   input  logic [NUM_DOMAINS-1:0] sw_rst_req,
   output logic [NUM_DOMAINS-1:0] dom_rst_n,
   output logic                   rst_done,
   output logic                   busy
);

   localparam int CW = cnt_width(PULSE_CYCLES, GAP_CYCLES);
   localparam int IW = $clog2(NUM_DOMAINS + 1);
   localparam logic [CW-1:0] HOLD_LAST = CW'(PULSE_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
   localparam logic [IW-1:0] DOM_LAST  = IW'(NUM_DOMAINS - 1);

   if (PULSE_CYCLES < 1) begin : g_chk_pulse
      $error("PULSE_CYCLES must be >= 1");
   end
   if (GAP_CYCLES < 1) begin : g_chk_gap
      $error("GAP_CYCLES must be >= 1");
   end
   if (SYNC_STAGES < 2) begin : g_chk_sync
      $error("SYNC_STAGES must be >= 2");
   end
   if (NUM_DOMAINS < 1) begin : g_chk_dom
      $error("NUM_DOMAINS must be >= 1");
   end

   rs_state_e              state;
   logic [CW-1:0]          cnt;
   logic [IW-1:0]          idx;
   logic                   rst_sync_n;
   logic                   hold_end;
   logic                   gap_end;
   logic                   run_nx;
   logic [NUM_DOMAINS-1:0] rel;
   logic [NUM_DOMAINS-1:0] pact_nx;

   reset_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk       (clk),
      .s_rst_n   (s_rst_n),
      .rst_sync_n(rst_sync_n)
   );

   // ST_SYNC behaves as the first hold cycle: the
   // synchroniser output is seen one edge after t0
   assign hold_end = (state == ST_SYNC || state == ST_HOLD)
                     && cnt == HOLD_LAST;
   assign gap_end  = state == ST_RELEASE && cnt == GAP_LAST;
   assign run_nx   = !sw_rst_all
                     && (state == ST_RUN || rel[NUM_DOMAINS-1]);

   // sequencing FSM: hold all, then release in index order
   always_ff @(posedge clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         state    <= ST_SYNC;
         cnt      <= '0;
         idx      <= '0;
         rst_done <= 1'b0;
      end else if (sw_rst_all) begin
         state    <= ST_HOLD;
         cnt      <= '0;
         idx      <= '0;
         rst_done <= 1'b0;
      end else begin
         unique case (state)
            ST_SYNC, ST_HOLD: begin
               if (hold_end) begin
                  cnt <= '0;
                  if (DOM_LAST == '0) begin
                     state    <= ST_RUN;
                     rst_done <= 1'b1;
                  end else begin
                     state <= ST_RELEASE;
                     idx   <= IW'(1);
                  end
               end else begin
                  cnt   <= cnt + CW'(1);
                  state <= ST_HOLD;
               end
            end
            ST_RELEASE: begin
               if (gap_end) begin
                  cnt <= '0;
                  if (idx == DOM_LAST) begin
                     state    <= ST_RUN;
                     rst_done <= 1'b1;
                  end else begin
                     idx <= idx + IW'(1);
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_RUN: ;
         endcase
      end
   end

   for (genvar i = 0; i < NUM_DOMAINS; i++) begin : g_dom
      logic          dom_q;
      logic          pact;
      logic [CW-1:0] pcnt;
      logic          req_ok;
      logic          pdone;

      assign req_ok  = state == ST_RUN && sw_rst_req[i];
      assign pdone   = pact && pcnt == HOLD_LAST;
      assign rel[i]  = !sw_rst_all
                       && ((i == 0 && hold_end)
                           || (gap_end && idx == IW'(i)));
      assign pact_nx[i] = !sw_rst_all
                          && (req_ok || (pact && !pdone));

      // domain reset flop plus its sw pulse counter
      always_ff @(posedge clk or negedge rst_sync_n) begin
         if (!rst_sync_n) begin
            dom_q <= 1'b0;
            pact  <= 1'b0;
            pcnt  <= '0;
         end else if (sw_rst_all) begin
            dom_q <= 1'b0;
            pact  <= 1'b0;
            pcnt  <= '0;
         end else if (rel[i]) begin
            dom_q <= 1'b1;
         end else if (req_ok) begin
            dom_q <= 1'b0;
            pact  <= 1'b1;
            pcnt  <= '0;
         end else if (pdone) begin
            dom_q <= 1'b1;
            pact  <= 1'b0;
         end else if (pact) begin
            pcnt <= pcnt + CW'(1);
         end
      end

      assign dom_rst_n[i] = dom_q;
   end

   // busy registered from next-cycle run/pulse status
   always_ff @(posedge clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         busy <= 1'b1;
      end else begin
         busy <= !run_nx || (|pact_nx);
      end
   end

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// tb_reset_seq_ctrl: directed bench with a timeline
// model for a default and a 4-domain instance
module tb_reset_seq_ctrl;

   logic       clk     = 1'b0;
   logic       s_rst_n = 1'b1;
   logic [1:0] sw_all  = '0;
   logic [3:0] req [2];
   logic [1:0] dom_a;
   logic [3:0] dom_b;
   logic       done_a, done_b, busy_a, busy_b;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   reset_seq_ctrl dut_a (
      .clk       (clk),
      .s_rst_n   (s_rst_n),
      .sw_rst_all(sw_all[0]),
      .sw_rst_req(req[0][1:0]),
      .dom_rst_n (dom_a),
      .rst_done  (done_a),
      .busy      (busy_a)
   );

   reset_seq_ctrl #(
      .NUM_DOMAINS (4),
      .SYNC_STAGES (2),
      .PULSE_CYCLES(1),
      .GAP_CYCLES  (1)
   ) dut_b (
      .clk       (clk),
      .s_rst_n   (s_rst_n),
      .sw_rst_all(sw_all[1]),
      .sw_rst_req(req[1]),
      .dom_rst_n (dom_b),
      .rst_done  (done_b),
      .busy      (busy_b)
   );

   function automatic int np(input int d);
      return (d == 0) ? 2 : 4;
   endfunction
   function automatic int pp(input int d);
      return (d == 0) ? 8 : 1;
   endfunction
   function automatic int gp(input int d);
      return (d == 0) ? 4 : 1;
   endfunction
   function automatic int lastrel(input int d);
      return pp(d) + (np(d) - 1) * gp(d);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h want %0h",
                  nm, $time, act, exp);
      end
   endtask

   // timeline model: t0 = edge the sequence (re)starts,
   // pend = edge after which a sw pulse ends
   int cyc  = 0;
   int sync = 0;
   int t0 [2] = '{-1, -1};
   int pend [2][4] = '{default: -1};

   always @(posedge clk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         sync = 0;
         for (int d = 0; d < 2; d++) begin
            t0[d] = -1;
            for (int k = 0; k < 4; k++) pend[d][k] = -1;
         end
      end else begin
         cyc++;
         sync++;
         for (int d = 0; d < 2; d++) begin
            if (t0[d] < 0) begin
               if (sync == 2) t0[d] = cyc;
            end else if (sw_all[d]) begin
               t0[d] = cyc;
               for (int k = 0; k < 4; k++) pend[d][k] = -1;
            end else if (cyc > t0[d] + lastrel(d)) begin
               for (int k = 0; k < np(d); k++)
                  if (req[d][k]) pend[d][k] = cyc + pp(d);
            end
         end
      end
   end

   logic [3:0] e_dom, a_dom;
   logic       e_done, e_busy, a_done, a_busy;

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         e_dom  = '0;
         e_done = t0[d] >= 0 && cyc - t0[d] >= lastrel(d);
         e_busy = !e_done;
         for (int k = 0; k < np(d); k++) begin
            e_dom[k] = t0[d] >= 0
                       && cyc - t0[d] >= pp(d) + k * gp(d)
                       && cyc >= pend[d][k];
            if (pend[d][k] > cyc) e_busy = 1'b1;
         end
         a_dom  = (d == 0) ? {2'b00, dom_a} : dom_b;
         a_done = (d == 0) ? done_a : done_b;
         a_busy = (d == 0) ? busy_a : busy_b;
         chk($sformatf("model_dom%0d", d), a_dom, e_dom);
         chk($sformatf("model_done%0d", d), a_done, e_done);
         chk($sformatf("model_busy%0d", d), a_busy, e_busy);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      req[0] = '0;
      req[1] = '0;
      #1 s_rst_n = 1'b0;
      step(1);
      chk("por_dom_a", dom_a, 2'b00);
      chk("por_done_a", done_a, 1'b0);
      chk("por_busy_a", busy_a, 1'b1);
      step(4);
      s_rst_n = 1'b1;
      step(3);
      chk("pon_b_e3", dom_b, 4'b0001);
      step(1);
      chk("pon_b_e4", dom_b, 4'b0011);
      step(1);
      chk("pon_b_e5", dom_b, 4'b0111);
      chk("pon_b_done5", done_b, 1'b0);
      step(1);
      chk("pon_b_e6", dom_b, 4'b1111);
      chk("pon_b_done6", done_b, 1'b1);
      step(3);
      chk("pon_a_e9", dom_a, 2'b00);
      chk("pon_a_done9", done_a, 1'b0);
      step(1);
      chk("pon_a_e10", dom_a, 2'b01);
      step(3);
      chk("pon_a_e13", dom_a, 2'b01);
      chk("pon_a_done13", done_a, 1'b0);
      step(1);
      chk("pon_a_e14", dom_a, 2'b11);
      chk("pon_a_done14", done_a, 1'b1);
      chk("pon_a_busy14", busy_a, 1'b0);

      step(2);
      req[0] = 4'b0010;
      req[1] = 4'b0100;
      step(1);
      req[0] = '0;
      req[1] = '0;
      chk("pulse_a_start", dom_a, 2'b01);
      chk("pulse_a_done", done_a, 1'b1);
      chk("pulse_a_busy", busy_a, 1'b1);
      chk("pulse_b_start", dom_b, 4'b1011);
      step(1);
      chk("pulse_b_end", dom_b, 4'b1111);
      chk("pulse_b_busy", busy_b, 1'b0);
      step(6);
      chk("pulse_a_e7", dom_a, 2'b01);
      chk("pulse_a_busy7", busy_a, 1'b1);
      step(1);
      chk("pulse_a_e8", dom_a, 2'b11);
      chk("pulse_a_busy8", busy_a, 1'b0);

      step(2);
      req[0] = 4'b0010;
      step(1);
      req[0] = '0;
      step(4);
      req[0] = 4'b0010;
      step(1);
      req[0] = '0;
      step(7);
      chk("repulse_e12", dom_a, 2'b01);
      step(1);
      chk("repulse_e13", dom_a, 2'b11);

      step(2);
      sw_all = 2'b11;
      step(1);
      sw_all = '0;
      chk("all_a_e0", dom_a, 2'b00);
      chk("all_a_done0", done_a, 1'b0);
      chk("all_a_busy0", busy_a, 1'b1);
      chk("all_b_e0", dom_b, 4'b0000);
      step(7);
      chk("all_a_e7", dom_a, 2'b00);
      step(1);
      chk("all_a_e8", dom_a, 2'b01);
      step(3);
      chk("all_a_e11", dom_a, 2'b01);
      chk("all_a_done11", done_a, 1'b0);
      step(1);
      chk("all_a_e12", dom_a, 2'b11);
      chk("all_a_done12", done_a, 1'b1);

      step(2);
      sw_all = 2'b01;
      req[0] = 4'b0001;
      step(1);
      sw_all = '0;
      req[0] = '0;
      chk("both_e0", dom_a, 2'b00);
      step(1);
      req[0] = 4'b0011;
      step(1);
      req[0] = '0;
      step(6);
      chk("both_e8", dom_a, 2'b01);
      req[0] = 4'b0001;
      step(1);
      req[0] = '0;
      step(3);
      chk("both_e12", dom_a, 2'b11);
      chk("both_done12", done_a, 1'b1);
      chk("both_busy12", busy_a, 1'b0);

      step(2);
      sw_all = 2'b01;
      step(1);
      sw_all = '0;
      step(9);
      chk("restart_e9", dom_a, 2'b01);
      sw_all = 2'b01;
      step(1);
      sw_all = '0;
      chk("restart_e10", dom_a, 2'b00);
      step(7);
      chk("restart_e17", dom_a, 2'b00);
      step(1);
      chk("restart_e18", dom_a, 2'b01);
      step(4);
      chk("restart_e22", dom_a, 2'b11);
      chk("restart_done22", done_a, 1'b1);

      step(2);
      req[0] = 4'b0010;
      step(1);
      req[0] = '0;
      step(2);
      #2 s_rst_n = 1'b0;
      #1;
      chk("async_dom_a", dom_a, 2'b00);
      chk("async_done_a", done_a, 1'b0);
      chk("async_busy_a", busy_a, 1'b1);
      chk("async_dom_b", dom_b, 4'b0000);
      chk("async_done_b", done_b, 1'b0);
      step(3);
      s_rst_n = 1'b1;
      step(9);
      chk("reseq_e9", dom_a, 2'b00);
      step(1);
      chk("reseq_e10", dom_a, 2'b01);
      step(4);
      chk("reseq_e14", dom_a, 2'b11);
      chk("reseq_done14", done_a, 1'b1);
      step(5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
